// File: rtl/cpu_exec_core.sv
// TinyCPU execute core: free-running instruction stage counter plus the operand
// mux and combinational 32-bit ALU that it steers (PC increment in the PC stage).
module cpu_exec_core #(
  parameter int NUM_STAGES  = 5,
  parameter int STAGE_FETCH = 0,
  parameter int STAGE_PC    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_output,
  input  logic [2:0]  alu_operation,
  input  logic [31:0] reg_value_0,
  input  logic [31:0] reg_value_1,
  output logic [2:0]  current_stage,
  output logic        is_stage_instr_fetch,
  output logic        is_stage_PC_update,
  output logic [31:0] alu_in0,
  output logic [31:0] alu_in1,
  output logic [2:0]  alu_op_select,
  output logic [31:0] alu_result
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLL  = 3'b101,
    ALU_SRL  = 3'b110,
    ALU_SLTU = 3'b111
  } alu_op_e;

  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic [2:0] FETCH_CODE = 3'(STAGE_FETCH);
  localparam logic [2:0] PC_CODE    = 3'(STAGE_PC);

  logic [2:0] stage_q, stage_d;

  // The stage register is the only state; it doubles as the observable FSM state.
  always_comb begin
    stage_d = stage_q + 3'd1;
    if (stage_q == LAST_STAGE) begin
      stage_d = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= 3'd0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign current_stage        = stage_q;
  assign is_stage_instr_fetch = (stage_q == FETCH_CODE);
  assign is_stage_PC_update   = (stage_q == PC_CODE);

  always_comb begin
    alu_in0       = reg_value_0;
    alu_in1       = reg_value_1;
    alu_op_select = alu_operation;
    if (is_stage_PC_update) begin
      alu_in0       = PC_output;
      alu_in1       = 32'd1;
      alu_op_select = ALU_ADD;
    end
  end

  // Shifts use only the low five bits of operand B.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op_select)
      ALU_ADD:  alu_result = alu_in0 + alu_in1;
      ALU_SUB:  alu_result = alu_in0 - alu_in1;
      ALU_AND:  alu_result = alu_in0 & alu_in1;
      ALU_OR:   alu_result = alu_in0 | alu_in1;
      ALU_XOR:  alu_result = alu_in0 ^ alu_in1;
      ALU_SLL:  alu_result = alu_in0 << alu_in1[4:0];
      ALU_SRL:  alu_result = alu_in0 >> alu_in1[4:0];
      ALU_SLTU: alu_result = {31'd0, (alu_in0 < alu_in1)};
      default:  alu_result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cpu_exec_core.sv
// Directed bench for cpu_exec_core: stage sequencing, async reset, PC-stage mux,
// every ALU opcode with hand-computed vectors, then a random sweep vs a model.
module tb_cpu_exec_core;

  logic        clk;
  logic        rst;
  logic [31:0] PC_output;
  logic [2:0]  alu_operation;
  logic [31:0] reg_value_0;
  logic [31:0] reg_value_1;
  logic [2:0]  current_stage;
  logic        is_stage_instr_fetch;
  logic        is_stage_PC_update;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [2:0]  alu_op_select;
  logic [31:0] alu_result;

  int total;
  int bad;

  cpu_exec_core #(.NUM_STAGES(5), .STAGE_FETCH(0), .STAGE_PC(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .PC_output            (PC_output),
    .alu_operation        (alu_operation),
    .reg_value_0          (reg_value_0),
    .reg_value_1          (reg_value_1),
    .current_stage        (current_stage),
    .is_stage_instr_fetch (is_stage_instr_fetch),
    .is_stage_PC_update   (is_stage_PC_update),
    .alu_in0              (alu_in0),
    .alu_in1              (alu_in1),
    .alu_op_select        (alu_op_select),
    .alu_result           (alu_result)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to the requested stage within a bounded number of clocks.
  task automatic goto_stage(input logic [2:0] s);
    int n;
    n = 0;
    while (current_stage !== s && n < 8) begin
      step();
      n++;
    end
    chk("goto_stage", {29'd0, current_stage}, {29'd0, s});
  endtask

  task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input logic [31:0] exp);
    alu_operation = op;
    reg_value_0   = a;
    reg_value_1   = b;
    #1;
    chk(tag, alu_result, exp);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    PC_output     = 32'h0000_1234;
    alu_operation = 3'd2;
    reg_value_0   = 32'h1111_0000;
    reg_value_1   = 32'h0000_2222;

    // Reset state: stage 0, fetch flag, register path through the mux.
    #12;
    chk("rst_stage", {29'd0, current_stage}, 32'd0);
    chk("rst_fetch", {31'd0, is_stage_instr_fetch}, 32'd1);
    chk("rst_pcupd", {31'd0, is_stage_PC_update}, 32'd0);
    chk("rst_in0", alu_in0, 32'h1111_0000);
    chk("rst_in1", alu_in1, 32'h0000_2222);
    chk("rst_op", {29'd0, alu_op_select}, 32'd2);
    chk("rst_res", alu_result, 32'h0000_0000);
    rst = 1'b0;

    // Test 1: async reset mid stage 2, then the full sequence.
    step();
    chk("seq_s1", {29'd0, current_stage}, 32'd1);
    step();
    chk("seq_s2", {29'd0, current_stage}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {29'd0, current_stage}, 32'd0);
    step();
    chk("rst_hold", {29'd0, current_stage}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("post_rst", {29'd0, current_stage}, 32'd0);
    chk("post_rst_fetch", {31'd0, is_stage_instr_fetch}, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      logic [2:0] exp_s;
      exp_s = 3'(i % 5);
      step();
      chk("seq_stage", {29'd0, current_stage}, {29'd0, exp_s});
      chk("seq_fetch", {31'd0, is_stage_instr_fetch}, {31'd0, (exp_s == 3'd0)});
      chk("seq_pcupd", {31'd0, is_stage_PC_update}, {31'd0, (exp_s == 3'd4)});
    end

    // Test 2: PC stage forces PC+1 regardless of decoded opcode.
    goto_stage(3'd4);
    PC_output     = 32'h0000_07FF;
    alu_operation = 3'b001;
    reg_value_0   = 32'hDEAD_BEEF;
    reg_value_1   = 32'h0000_0055;
    #1;
    chk("pc_in0", alu_in0, 32'h0000_07FF);
    chk("pc_in1", alu_in1, 32'h0000_0001);
    chk("pc_op", {29'd0, alu_op_select}, 32'd0);
    chk("pc_res", alu_result, 32'h0000_0800);
    chk("pc_flag", {31'd0, is_stage_PC_update}, 32'd1);
    chk("pc_fetch", {31'd0, is_stage_instr_fetch}, 32'd0);

    // Test 3: add/sub wrap.
    goto_stage(3'd2);
    apply(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap", 32'h0000_0000);
    chk("mux_op", {29'd0, alu_op_select}, 32'd0);
    apply(3'd1, 32'h0000_0000, 32'h0000_0001, "sub_wrap", 32'hFFFF_FFFF);
    chk("mux_in0", alu_in0, 32'h0000_0000);

    // Test 4: logic ops.
    goto_stage(3'd2);
    apply(3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, "and", 32'h00F0_000F);
    apply(3'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, "or", 32'hFFF0_0FFF);
    apply(3'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, "xor", 32'hFF00_0FF0);

    // Test 5: shifts with upper shamt bits ignored, unsigned compare.
    goto_stage(3'd2);
    apply(3'd5, 32'h8000_0001, 32'h0000_0024, "sll", 32'h0000_0010);
    apply(3'd6, 32'h8000_0001, 32'h0000_0024, "srl", 32'h0800_0000);
    apply(3'd7, 32'h0000_0005, 32'h0000_0007, "sltu_lt", 32'h0000_0001);
    apply(3'd7, 32'h0000_0007, 32'h0000_0005, "sltu_gt", 32'h0000_0000);
    apply(3'd7, 32'hFFFF_FFFF, 32'h0000_0001, "sltu_big", 32'h0000_0000);

    // Test 6: random sweep against the reference model.
    for (int i = 0; i < 10000; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b, pc;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      pc = $urandom;
      alu_operation = op;
      reg_value_0   = a;
      reg_value_1   = b;
      PC_output     = pc;
      #1;
      if (current_stage == 3'd4) begin
        chk("rnd_pc_in0", alu_in0, pc);
        chk("rnd_pc_res", alu_result, pc + 32'd1);
      end else begin
        chk("rnd_in0", alu_in0, a);
        chk("rnd_in1", alu_in1, b);
        chk("rnd_op", {29'd0, alu_op_select}, {29'd0, op});
        chk("rnd_res", alu_result, ref_alu(op, a, b));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
